fcache_line_fill: RTL and testbench

FCACHE_LINE_FILL -- requirements
Module: fcache_line_fill

---
 rtl/fcache_line_fill.sv | 96 +++++++++
 tb/tb_fcache_line_fill.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fcache_line_fill.sv
// rtl/fcache_line_fill.sv - assembles a 16-word cache line from memory and commits it to fcache
// Optional abort input enabled by defining FCACHE_LINE_FILL_ABORT_EN.
module fcache_line_fill (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  lineAddr,
`ifdef FCACHE_LINE_FILL_ABORT_EN
    input  logic         abort,
`endif
    output logic         memReq,
    output logic [15:0]  memAddr,
    input  logic         memValid,
    input  logic [15:0]  memData,
    output logic         write,
    output logic [15:0]  addr,
    output logic [255:0] wData,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [15:0]  addr_q, addr_d;
    logic [255:0] wdata_q, wdata_d;
    logic         done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = (state_q == S_COMMIT);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = 4'd0;
                    addr_d  = lineAddr;
                end
            end
            S_FETCH: begin
`ifdef FCACHE_LINE_FILL_ABORT_EN
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                end else
`endif
                if (memValid) begin
                    wdata_d[{idx_q, 4'b0000} +: 16] = memData;
                    // idx wraps to 0 on the last word, so it never indexes past 15
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'hF) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            addr_q  <= 16'd0;
            wdata_q <= 256'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // lineAddr[15:12] falls off the word address but is kept for the fcache address
    assign memAddr = {addr_q[11:0], idx_q};
    assign memReq  = (state_q == S_FETCH);
    assign write   = (state_q == S_COMMIT);
    assign busy    = (state_q == S_FETCH) || (state_q == S_COMMIT);
    assign done    = done_q;
    assign addr    = addr_q;
    assign wData   = wdata_q;

endmodule

// File: tb/tb_fcache_line_fill.sv
// tb/tb_fcache_line_fill.sv - directed scoreboard bench for fcache_line_fill
// Abort scenario runs when FCACHE_LINE_FILL_ABORT_EN is defined.
module tb_fcache_line_fill;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  lineAddr;
    logic         memValid;
    logic [15:0]  memData;
    logic         memReq;
    logic [15:0]  memAddr;
    logic         write;
    logic [15:0]  addr;
    logic [255:0] wData;
    logic         busy;
    logic         done;
`ifdef FCACHE_LINE_FILL_ABORT_EN
    logic         abort;
`endif

    fcache_line_fill dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .lineAddr(lineAddr),
`ifdef FCACHE_LINE_FILL_ABORT_EN
        .abort(abort),
`endif
        .memReq(memReq),
        .memAddr(memAddr),
        .memValid(memValid),
        .memData(memData),
        .write(write),
        .addr(addr),
        .wData(wData),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int writes = 0;
    int dones = 0;
    int cyc = 0;
    int last_write_cyc = 0;
    int last_done_cyc = 0;
    logic [15:0]  exp_addr_q[$];
    logic [255:0] exp_line_q[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and retire any write against the scoreboard.
    task automatic step();
        logic [15:0]  ea;
        logic [255:0] el;
        @(posedge clk);
        #1;
        cyc++;
        if (write === 1'b1) begin
            writes++;
            last_write_cyc = cyc;
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", 256'(1), 256'(0));
            end else begin
                ea = exp_addr_q.pop_front();
                el = exp_line_q.pop_front();
                check("write_addr", 256'(addr), 256'(ea));
                check("write_line", wData, el);
            end
        end
        if (done === 1'b1) begin
            dones++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write"}, 256'(write), 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_memreq"}, 256'(memReq), 256'(0));
        check({tag, "_memaddr"}, 256'(memAddr), 256'(0));
        check({tag, "_addr"}, 256'(addr), 256'(0));
        check({tag, "_wdata"}, wData, 256'(0));
    endtask

    // Full fill; toggle alternates memValid 1,0,..., disturb pulses start and moves lineAddr.
    task automatic fill(input logic [15:0] la, input logic [15:0] base, input bit toggle,
                        input bit disturb, input int exp_wr_rel);
        logic [255:0] line;
        int k;
        int t0;
        int w0;
        int d0;
        bit ph;
        for (int i = 0; i < 16; i++) line[16*i +: 16] = base + 16'(i);
        exp_addr_q.push_back(la);
        exp_line_q.push_back(line);
        w0 = writes;
        d0 = dones;
        lineAddr = la;
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        k = 0;
        ph = 1'b1;
        for (int n = 0; n < 64 && k < 16; n++) begin
            check("memaddr", 256'(memAddr), 256'({la[11:0], 4'(k)}));
            check("memreq", 256'(memReq), 256'(1));
            memValid = ph;
            memData = base + 16'(k);
            if (disturb) begin
                start = n[0];
                lineAddr = 16'hFFFF;
            end
            step();
            if (ph) k++;
            if (toggle) ph = ~ph;
        end
        memValid = 1'b0;
        start = 1'b0;
        for (int n = 0; n < 4 && writes == w0; n++) step();
        check("write_count", 256'(writes - w0), 256'(1));
        check("write_latency", 256'(last_write_cyc - t0), 256'(exp_wr_rel));
        step();
        check("done_pulse", 256'(done), 256'(1));
        check("done_count", 256'(dones - d0), 256'(1));
        check("done_latency", 256'(last_done_cyc - t0), 256'(exp_wr_rel + 1));
        check("idle_after_done", 256'(busy), 256'(0));
    endtask

    initial begin
        int w0;
        int d0;
        logic [255:0] prev_line;
        reset = 1'b1;
        start = 1'b0;
        lineAddr = 16'h0;
        memValid = 1'b0;
        memData = 16'h0;
`ifdef FCACHE_LINE_FILL_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        check_all_zero("reset");
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_write", 256'(write), 256'(0));
            check("idle_done", 256'(done), 256'(0));
            check("idle_busy", 256'(busy), 256'(0));
            check("idle_memreq", 256'(memReq), 256'(0));
            check("idle_wdata", wData, 256'(0));
        end

        fill(16'h1234, 16'h0000, 1'b0, 1'b0, 17);
        prev_line = wData;
        for (int i = 0; i < 3; i++) step();
        check("hold_addr", 256'(addr), 256'(16'h1234));
        check("hold_wdata", wData, prev_line);

        fill(16'hA5C3, 16'h4000, 1'b1, 1'b0, 32);
        // start is driven in the done cycle of the previous fill
        fill(16'h7E01, 16'h9100, 1'b0, 1'b0, 17);
        fill(16'h2468, 16'hC000, 1'b0, 1'b1, 17);
        w0 = writes;
        for (int i = 0; i < 20; i++) step();
        check("no_extra_write", 256'(writes - w0), 256'(0));

        // Reset after 8 accepts abandons the fill.
        w0 = writes;
        d0 = dones;
        lineAddr = 16'h3C3C;
        start = 1'b1;
        step();
        start = 1'b0;
        memValid = 1'b1;
        memData = 16'h5555;
        for (int i = 0; i < 8; i++) step();
        check("partial_idx_memaddr", 256'(memAddr), 256'(16'hC3C8));
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        memValid = 1'b0;
        check("reset_no_write", 256'(writes - w0), 256'(0));
        check("reset_no_done", 256'(dones - d0), 256'(0));
        check_all_zero("post_reset");
        fill(16'hBEEF, 16'h0010, 1'b0, 1'b0, 17);

`ifdef FCACHE_LINE_FILL_ABORT_EN
        w0 = writes;
        d0 = dones;
        lineAddr = 16'h0ABC;
        start = 1'b1;
        step();
        start = 1'b0;
        memValid = 1'b1;
        memData = 16'h1111;
        for (int i = 0; i < 5; i++) step();
        check("abort_idx5", 256'(memAddr), 256'(16'hABC5));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_memreq", 256'(memReq), 256'(0));
        for (int i = 0; i < 20; i++) step();
        memValid = 1'b0;
        check("abort_no_write", 256'(writes - w0), 256'(0));
        check("abort_no_done", 256'(dones - d0), 256'(0));
        fill(16'h1357, 16'h2000, 1'b0, 1'b0, 17);
        fill(16'h9753, 16'h3000, 1'b0, 1'b0, 17);
`endif

        check("scoreboard_empty", 256'(exp_addr_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
